mem_access_ctrl: RTL

//  Sequences load/store instructions from the decode/execute stage onto the single data-memory

---
 rtl/mem_access_ctrl_pkg.sv | 58 +++++
 rtl/mem_access_ctrl_if.sv | 24 ++
 rtl/mem_access_ctrl_load_align.sv | 35 +++
 rtl/mem_access_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller and its users
// (decoder, write-back mux, fetch-path aligner).
//   - bhw size encodings and the decoded access size
//   - controller state encoding
//   - lane helpers: size decode, misalignment test, store strobes/replication
package mem_access_ctrl_pkg;

    // Controller states, 2-bit so other stages can observe/compare them
    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_REQ  = 2'd1,
        MS_WAIT = 2'd2,
        MS_DONE = 2'd3
    } mem_state_e;

    // Decoded access width
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_e;

    // Decoder bhw encodings
    localparam logic [3:0] BHW_B = 4'b0001;
    localparam logic [3:0] BHW_H = 4'b0011;
    localparam logic [3:0] BHW_W = 4'b1111;

    // Any encoding other than byte/half is treated as a full word
    function automatic mem_size_e decode_bhw(input logic [3:0] bhw);
        case (bhw)
            BHW_B:   return SZ_BYTE;
            BHW_H:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input mem_size_e sz, input logic [1:0] off);
        return ((sz == SZ_HALF) && off[0]) || ((sz == SZ_WORD) && (off != 2'b00));
    endfunction

    function automatic logic [3:0] lane_strobe(input mem_size_e sz, input logic [1:0] off);
        case (sz)
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the low bits across all lanes so the strobes alone pick the target
    function automatic logic [31:0] lane_wdata(input mem_size_e sz, input logic [31:0] wdata);
        case (sz)
            SZ_BYTE: return {4{wdata[7:0]}};
            SZ_HALF: return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory port bundle.
//   master (controller): dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata out;
//                        dmem_gnt, dmem_rvalid, dmem_rdata in
//   slave  (memory)    : the mirror image
interface mem_access_ctrl_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_access_ctrl_load_align.sv
// mem_load_align: combinational load formatter, shared with the fetch path.
//   rdata   in  32  raw word from memory
//   off     in  2   byte offset within the word
//   bhw     in  4   access size encoding
//   unsign  in  1   1 = zero-extend, 0 = sign-extend
//   ld_data out 32  aligned, extended result
module mem_load_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [3:0]  bhw,
    input  logic        unsign,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;
    mem_size_e   size;

    // Bring the addressed lane down to bit 0, then extend to 32 bits.
    // Words are always aligned, so the shift is a no-op for them.
    always_comb begin
        size    = decode_bhw(bhw);
        shifted = rdata >> {off, 3'b000};
        ld_data = shifted;
        case (size)
            SZ_BYTE: ld_data = unsign ? {24'b0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: ld_data = unsign ? {16'b0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: turns EX/MEM load/store instructions into dmem transactions.
//   clk, rst_n                 clock, async active-low reset
//   ex_valid, flush            instruction valid / kill
//   mem_re, mem_we, bhw,       access type, size, extension
//   load_unsign
//   addr, wdata                effective address, store data
//   stall                      hold the pipeline while an access is in flight
//   ld_valid, ld_data          load write-back pulse and result
//   misalign, bus_err          one-cycle error pulses
//   dmem                       data-memory port (master side)
// TIMEOUT: REQ+WAIT cycles before giving up with bus_err, 2..255.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        flush,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic [3:0]  bhw,
    input  logic        load_unsign,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic        misalign,
    output logic        bus_err,
    mem_access_ctrl_if.master dmem
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    mem_state_e  state, state_nxt;
    logic [7:0]  cnt;
    logic        kill;
    logic        timeout_fire;

    logic [29:0] lat_addr;
    logic [1:0]  lat_off;
    logic        lat_we;
    logic [3:0]  lat_strb;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_bhw;
    logic        lat_unsign;

    mem_size_e   size_in;
    logic        mis;
    logic        mem_op;
    logic        start;
    logic [31:0] ld_aligned;

    // Decode the incoming instruction; a misaligned op never reaches the bus
    always_comb begin
        size_in = decode_bhw(bhw);
        mis     = is_misaligned(size_in, addr[1:0]);
        mem_op  = ex_valid & (mem_re | mem_we) & ~flush;
        start   = (state == MS_IDLE) & mem_op & ~mis;
    end

    // Next state and combinational outputs. Priority in REQ is grant, then
    // flush, then timeout; in WAIT a final rvalid beats the timeout.
    always_comb begin
        state_nxt     = state;
        stall         = 1'b0;
        dmem.dmem_req = 1'b0;
        ld_valid      = 1'b0;
        timeout_fire  = 1'b0;
        case (state)
            MS_IDLE: begin
                if (start) begin
                    stall     = 1'b1;
                    state_nxt = MS_REQ;
                end
            end
            MS_REQ: begin
                stall         = 1'b1;
                dmem.dmem_req = 1'b1;
                if (dmem.dmem_gnt) begin
                    state_nxt = lat_we ? MS_DONE : MS_WAIT;
                end else if (flush) begin
                    state_nxt = MS_IDLE;
                end else if (cnt >= TO_LAST) begin
                    state_nxt    = MS_DONE;
                    timeout_fire = 1'b1;
                end
            end
            MS_WAIT: begin
                stall = 1'b1;
                if (dmem.dmem_rvalid) begin
                    state_nxt = MS_DONE;
                end else if (cnt >= TO_LAST) begin
                    state_nxt    = MS_DONE;
                    timeout_fire = 1'b1;
                end
            end
            MS_DONE: begin
                ld_valid  = ~lat_we & ~kill & ~bus_err;
                state_nxt = MS_IDLE;
            end
            default: state_nxt = MS_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= MS_IDLE;
        else        state <= state_nxt;
    end

    // Capture the whole access at start so the bus stays stable while the
    // pipeline inputs are held or change under flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_addr   <= '0;
            lat_off    <= '0;
            lat_we     <= 1'b0;
            lat_strb   <= '0;
            lat_wdata  <= '0;
            lat_bhw    <= '0;
            lat_unsign <= 1'b0;
        end else if (start) begin
            lat_addr   <= addr[31:2];
            lat_off    <= addr[1:0];
            lat_we     <= mem_we;
            lat_strb   <= mem_we ? lane_strobe(size_in, addr[1:0]) : 4'b0000;
            lat_wdata  <= lane_wdata(size_in, wdata);
            lat_bhw    <= bhw;
            lat_unsign <= load_unsign;
        end
    end

    // Timeout counter spans REQ and WAIT together; saturates so a late
    // grant on the last REQ cycle still times out in WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (((state == MS_REQ) || (state == MS_WAIT)) && (cnt != 8'hFF)) begin
            cnt <= cnt + 8'd1;
        end
    end

    // A flush once the request is granted cannot recall it; remember it so
    // the returning data is consumed but not written back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kill <= 1'b0;
        end else if (start || (state == MS_DONE)) begin
            kill <= 1'b0;
        end else if (flush && (((state == MS_REQ) && dmem.dmem_gnt) || (state == MS_WAIT))) begin
            kill <= 1'b1;
        end
    end

    // Registered error pulses and load result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign <= 1'b0;
            bus_err  <= 1'b0;
            ld_data  <= '0;
        end else begin
            misalign <= (state == MS_IDLE) & mem_op & mis;
            bus_err  <= timeout_fire;
            if (timeout_fire) begin
                ld_data <= '0;
            end else if ((state == MS_WAIT) && dmem.dmem_rvalid) begin
                ld_data <= ld_aligned;
            end
        end
    end

    mem_load_align u_align (
        .rdata   (dmem.dmem_rdata),
        .off     (lat_off),
        .bhw     (lat_bhw),
        .unsign  (lat_unsign),
        .ld_data (ld_aligned)
    );

    assign dmem.dmem_we    = lat_we;
    assign dmem.dmem_addr  = {lat_addr, 2'b00};
    assign dmem.dmem_wstrb = lat_strb;
    assign dmem.dmem_wdata = lat_wdata;

endmodule
